fpu_cmd_driver: RTL and testbench
=================================

// Module: fpu_cmd_driver
// PURPOSE
//  Host-side driver for the 16-bit half-precision FPU load interface. It takes
//  one operation request (A, B, opcode) over a valid/ready handshake and plays
//  the FPU's word sequence onto its start/data pins. It then waits for the
//  FPU's ready/error completion and returns a status response with a latency
//  count. It sits between the command source (bus bridge or testbench
//  sequencer) and the FPU top.
// PARAMETERS
//  TIMEOUT  255  max WAIT-state cycle count before abort; must be < 2**CNT_W
//  CNT_W    8    width of the wait-cycle counter and rsp_cycles
// PORTS
//  clk          in   1      system clock, all logic on rising edge
//  rst          in   1      asynchronous reset, active-low (0 = reset)
//  req_valid    in   1      request present
//  req_ready    out  1      driver can accept request (IDLE only)
//  req_a        in   16     operand A, half-precision {sign,exp[4:0],frac[9:0]}
//  req_b        in   16     operand B, same format
//  req_op       in   2      FPU opcode
//  fpu_start    out  1      start strobe to FPU, 1 cycle, coincident with A word
//  fpu_data     out  16     word bus to FPU
//  fpu_ready    in   1      FPU completion
//  fpu_error    in   1      FPU error flag
//  rsp_valid    out  1      response held until acked
//  rsp_ack      in   1      response consumed
//  rsp_error    out  1      FPU reported error
//  rsp_timeout  out  1      no completion within TIMEOUT
//  rsp_cycles   out  CNT_W  WAIT cycles elapsed before completion
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, counter=0, captured regs=0. Outputs:
//    req_ready=1, fpu_start=0, fpu_data=0, rsp_valid=0, rsp_error=0,
//    rsp_timeout=0, rsp_cycles=0. Reset mid-operation aborts; no response.
//  - FSM: IDLE -> SEND_A -> SEND_B -> SEND_OP -> WAIT -> RESP -> IDLE.
//  - IDLE: req_ready=1. On req_valid=1, capture req_a/b/op and go to SEND_A.
//    Handshake completes in this same cycle.
//  - SEND_A: fpu_start=1, fpu_data=A. SEND_B: fpu_data=B. SEND_OP:
//    fpu_data={14'b0,op}. Each state lasts exactly 1 cycle. fpu_start is 0
//    everywhere except SEND_A. fpu_data is 0 outside SEND_*.
//  - SEND_OP clears the counter. First WAIT cycle has count=0.
//  - WAIT: each cycle, completion = fpu_ready|fpu_error.
//    - On completion: rsp_cycles<=count, rsp_error<=fpu_error, rsp_timeout<=0,
//      go to RESP.
//    - Else if count==TIMEOUT: rsp_timeout<=1, rsp_error<=0,
//      rsp_cycles<=TIMEOUT, go to RESP.
//    - Else count<=count+1.
//    - WAIT therefore lasts at most TIMEOUT+1 cycles. If completion and
//      count==TIMEOUT occur together, completion wins.
//  - RESP: rsp_valid=1; rsp_* stable until the rsp_ack cycle. On rsp_ack=1,
//    go to IDLE and clear rsp_valid. rsp_error/timeout/cycles hold their last
//    values until the next RESP.
//  - Request-to-start latency: fpu_start asserts 1 cycle after the accept edge.
//    Minimum request-to-request turnaround is 6 cycles.
//  - fpu_ready/fpu_error are ignored outside WAIT. req_valid is ignored
//    outside IDLE. rsp_ack is ignored outside RESP.
// TESTING
//  1 req a=3C00 b=4000 op=1; fpu_ready=1 on 3rd WAIT cycle -> data 3C00,4000,
//    0001 on consecutive cycles, start only with 3C00; rsp_valid, cycles=2,
//    error=0, timeout=0.
//  2 same req, fpu_error=1 with fpu_ready=1 in 1st WAIT cycle -> rsp_error=1,
//    rsp_cycles=0.
//  3 TIMEOUT=4, FPU silent -> WAIT 5 cycles, then rsp_timeout=1,
//    rsp_cycles=4; completion on 5th WAIT cycle -> timeout=0, cycles=4.
//  4 hold rsp_ack=0 for 5 cycles with req_valid=1 -> req_ready=0, no capture,
//    rsp stable; ack -> IDLE, next req accepted the following cycle.
//  5 rst=0 during WAIT -> all outputs at reset values immediately (async),
//    no rsp_valid after release.
//  6 fpu_ready pulses in IDLE/SEND_* -> ignored; state sequence unchanged.

Source files
------------

// File: rtl/fpu_cmd_driver.sv
// Host-side sequencer for the half-precision FPU load port: accepts one request, plays
// the A/B/opcode words, waits for completion (or timeout) and holds a status response.
module fpu_cmd_driver #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [15:0]      req_a,
  input  logic [15:0]      req_b,
  input  logic [1:0]       req_op,
  output logic             fpu_start,
  output logic [15:0]      fpu_data,
  input  logic             fpu_ready,
  input  logic             fpu_error,
  output logic             rsp_valid,
  input  logic             rsp_ack,
  output logic             rsp_error,
  output logic             rsp_timeout,
  output logic [CNT_W-1:0] rsp_cycles
);

  typedef enum logic [2:0] {
    StIdle, StSendA, StSendB, StSendOp, StWait, StResp
  } state_e;

  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic [15:0]      a_q, a_d, b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_error_q, rsp_error_d;
  logic             rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0] rsp_cycles_q, rsp_cycles_d;
  logic             done;

  assign done = fpu_ready | fpu_error;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      a_q           <= '0;
      b_q           <= '0;
      op_q          <= '0;
      cnt_q         <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_cycles_q  <= '0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      op_q          <= op_d;
      cnt_q         <= cnt_d;
      rsp_error_q   <= rsp_error_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_cycles_q  <= rsp_cycles_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    op_d          = op_q;
    cnt_d         = cnt_q;
    rsp_error_d   = rsp_error_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_cycles_d  = rsp_cycles_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          a_d     = req_a;
          b_d     = req_b;
          op_d    = req_op;
          state_d = StSendA;
        end
      end
      StSendA:  state_d = StSendB;
      StSendB:  state_d = StSendOp;
      StSendOp: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // Completion takes priority over a coincident timeout.
        if (done) begin
          rsp_cycles_d  = cnt_q;
          rsp_error_d   = fpu_error;
          rsp_timeout_d = 1'b0;
          state_d       = StResp;
        end else if (cnt_q == TimeoutVal) begin
          rsp_cycles_d  = TimeoutVal;
          rsp_error_d   = 1'b0;
          rsp_timeout_d = 1'b1;
          state_d       = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        if (rsp_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    fpu_start = 1'b0;
    fpu_data  = '0;
    rsp_valid = 1'b0;
    unique case (state_q)
      StIdle:  req_ready = 1'b1;
      StSendA: begin
        fpu_start = 1'b1;
        fpu_data  = a_q;
      end
      StSendB:  fpu_data = b_q;
      StSendOp: fpu_data = {14'b0, op_q};
      StWait:   ;
      StResp:   rsp_valid = 1'b1;
      default:  ;
    endcase
  end

  assign rsp_error   = rsp_error_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_cycles  = rsp_cycles_q;

endmodule

// File: tb/tb_fpu_cmd_driver.sv
// Self-checking bench for fpu_cmd_driver: expected responses are queued at request time
// and compared when the driver presents rsp_valid.
module tb_fpu_cmd_driver;

  localparam int unsigned TO = 4;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready;
  logic [15:0]   req_a, req_b;
  logic [1:0]    req_op;
  logic          fpu_start;
  logic [15:0]   fpu_data;
  logic          fpu_ready, fpu_error;
  logic          rsp_valid, rsp_ack, rsp_error, rsp_timeout;
  logic [CW-1:0] rsp_cycles;

  typedef struct {
    logic          err;
    logic          tmo;
    logic [CW-1:0] cyc;
  } exp_rsp_t;

  exp_rsp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  fpu_cmd_driver #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .fpu_start(fpu_start), .fpu_data(fpu_data),
    .fpu_ready(fpu_ready), .fpu_error(fpu_error),
    .rsp_valid(rsp_valid), .rsp_ack(rsp_ack),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout), .rsp_cycles(rsp_cycles)
  );

  always #5 clk = ~clk;

  // Starts and ends on a negedge with the DUT in IDLE. comp_at < 0 means the FPU stays silent.
  task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                         input int comp_at, input logic err, input int hold, input logic noise);
    exp_rsp_t e, got;
    int k;
    if (comp_at >= 0 && comp_at <= int'(TO)) begin
      e.err = err; e.tmo = 1'b0; e.cyc = CW'(comp_at);
    end else begin
      e.err = 1'b0; e.tmo = 1'b1; e.cyc = CW'(TO);
    end
    n_checks++;
    if (req_ready !== 1'b1) begin
      $display("FAIL idle_ready: got %b want 1", req_ready); n_fail++;
    end
    req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
    fpu_ready = noise; fpu_error = noise;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0; req_a = ~a; req_b = ~b; req_op = ~op;
    n_checks++;
    if (fpu_start !== 1'b1 || fpu_data !== a) begin
      $display("FAIL send_a: start=%b data=%h want start=1 data=%h", fpu_start, fpu_data, a);
      n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (fpu_start !== 1'b0 || fpu_data !== b) begin
      $display("FAIL send_b: start=%b data=%h want start=0 data=%h", fpu_start, fpu_data, b);
      n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (fpu_start !== 1'b0 || fpu_data !== {14'b0, op}) begin
      $display("FAIL send_op: start=%b data=%h want start=0 data=%h", fpu_start, fpu_data,
               {14'b0, op});
      n_fail++;
    end
    @(negedge clk);
    k = 0;
    forever begin
      fpu_ready = (k == comp_at);
      fpu_error = err && (k == comp_at);
      if (fpu_data !== 16'h0 || fpu_start !== 1'b0 || rsp_valid !== 1'b0) begin
        $display("FAIL wait_idle_bus: data=%h start=%b rsp_valid=%b want 0/0/0",
                 fpu_data, fpu_start, rsp_valid);
        n_fail++; n_checks++;
      end
      @(negedge clk);
      fpu_ready = 1'b0; fpu_error = 1'b0;
      if (rsp_valid === 1'b1) break;
      k++;
      if (k > 20) begin
        $display("FAIL rsp_timeout_bound: no rsp_valid after %0d wait cycles, want <= %0d",
                 k, TO + 1);
        n_fail++; n_checks++;
        return;
      end
    end
    n_checks++;
    if (k + 1 != int'(e.cyc) + 1) begin
      $display("FAIL wait_len: got %0d wait cycles want %0d", k + 1, int'(e.cyc) + 1);
      n_fail++;
    end
    n_checks++;
    if (sb.size() == 0) begin
      $display("FAIL sb_empty: response with no queued expectation, want one queued");
      n_fail++;
      return;
    end
    got = sb.pop_front();
    n_checks++;
    if (rsp_error !== got.err || rsp_timeout !== got.tmo || rsp_cycles !== got.cyc) begin
      $display("FAIL rsp_fields: err=%b tmo=%b cyc=%0d want err=%b tmo=%b cyc=%0d",
               rsp_error, rsp_timeout, rsp_cycles, got.err, got.tmo, got.cyc);
      n_fail++;
    end
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_a = 16'hdead; fpu_ready = 1'b1; fpu_error = 1'b1;
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_error !== got.err ||
          rsp_timeout !== got.tmo || rsp_cycles !== got.cyc || fpu_start !== 1'b0) begin
        $display("FAIL resp_hold: valid=%b ready=%b err=%b tmo=%b cyc=%0d want 1/0/%b/%b/%0d",
                 rsp_valid, req_ready, rsp_error, rsp_timeout, rsp_cycles,
                 got.err, got.tmo, got.cyc);
        n_fail++;
      end
    end
    req_valid = 1'b0; fpu_ready = 1'b0; fpu_error = 1'b0; rsp_ack = 1'b1;
    @(negedge clk);
    rsp_ack = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_error !== got.err ||
        rsp_timeout !== got.tmo || rsp_cycles !== got.cyc) begin
      $display("FAIL after_ack: valid=%b ready=%b err=%b tmo=%b cyc=%0d want 0/1/%b/%b/%0d",
               rsp_valid, req_ready, rsp_error, rsp_timeout, rsp_cycles,
               got.err, got.tmo, got.cyc);
      n_fail++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_checks++;
    if (req_ready !== 1'b1 || fpu_start !== 1'b0 || fpu_data !== 16'h0 ||
        rsp_valid !== 1'b0 || rsp_error !== 1'b0 || rsp_timeout !== 1'b0 ||
        rsp_cycles !== '0) begin
      $display("FAIL %s: ready=%b start=%b data=%h valid=%b err=%b tmo=%b cyc=%0d want 1/0/0/0/0/0/0",
               tag, req_ready, fpu_start, fpu_data, rsp_valid, rsp_error, rsp_timeout,
               rsp_cycles);
      n_fail++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0;
    fpu_ready = 1'b0; fpu_error = 1'b0; rsp_ack = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_release");
  endtask

  task automatic test_basic();
    run_txn(16'h3C00, 16'h4000, 2'd1, 2, 1'b0, 0, 1'b0);
  endtask

  task automatic test_error();
    run_txn(16'h3C00, 16'h4000, 2'd1, 0, 1'b1, 0, 1'b0);
  endtask

  task automatic test_timeout();
    run_txn(16'hC500, 16'h7BFF, 2'd2, -1, 1'b0, 0, 1'b0);
    run_txn(16'h0001, 16'h8000, 2'd3, int'(TO), 1'b0, 0, 1'b0);
    run_txn(16'h1234, 16'h5678, 2'd0, int'(TO), 1'b1, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_txn(16'hABCD, 16'h0F0F, 2'd2, 1, 1'b0, 5, 1'b0);
    run_txn(16'h5555, 16'hAAAA, 2'd3, 3, 1'b1, 1, 1'b0);
  endtask

  task automatic test_abort();
    req_a = 16'h4200; req_b = 16'h4400; req_op = 2'd1; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      fpu_ready = i[0];
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        $display("FAIL abort_quiet: valid=%b ready=%b want 0/1", rsp_valid, req_ready);
        n_fail++;
      end
    end
    fpu_ready = 1'b0;
  endtask

  task automatic test_noise();
    for (int i = 0; i < 4; i++) begin
      fpu_ready = 1'b1; fpu_error = i[0];
      @(negedge clk);
      n_checks++;
      if (req_ready !== 1'b1 || fpu_start !== 1'b0 || rsp_valid !== 1'b0) begin
        $display("FAIL idle_noise: ready=%b start=%b valid=%b want 1/0/0",
                 req_ready, fpu_start, rsp_valid);
        n_fail++;
      end
    end
    fpu_ready = 1'b0; fpu_error = 1'b0;
    run_txn(16'h3555, 16'hBC00, 2'd0, 3, 1'b0, 0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      run_txn(16'($urandom), 16'($urandom), 2'($urandom_range(3)),
              int'($urandom_range(TO + 1)) - 1, 1'($urandom_range(1)),
              int'($urandom_range(2)), 1'($urandom_range(1)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_error();
    test_timeout();
    test_back_to_back();
    test_abort();
    test_noise();
    test_random();
    n_checks++;
    if (sb.size() != 0) begin
      $display("FAIL sb_leftover: %0d expectations unconsumed, want 0", sb.size());
      n_fail++;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
